rv32f_data_ram: RTL and testbench

- Word-addressed data-memory responder serving the single-precision load/store port of the RV32F execution unit: FLW reads and FSW writes.
- Accepts one request per handshake and performs writes in a single cycle.
- Returns read data after a fixed, parameterised latency with a one-cycle valid strobe.
- Sits between the floating-point unit's RAM request outputs and the core's data bus.

---
 rtl/rv32f_data_ram.sv | 79 +++++++
 tb/tb_rv32f_data_ram.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rv32f_data_ram.sv
// rv32f_data_ram: word-addressed FLW/FSW data memory with byte-lane writes and fixed read latency
module rv32f_data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iRAM_CE,
    input  logic              iRAM_RD,
    input  logic              iRAM_WR,
    input  logic [ADDR_W-1:0] iRAM_ADDR,
    input  logic [3:0]        iRAM_BE,
    input  logic [31:0]       iRAM_DATA,
    output logic              oRAM_READY,
    output logic              oRAM_VALID,
    output logic [31:0]       oRAM_DATA,
    output logic              oRAM_ERR
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} stateT;

    stateT             state;
    logic [3:0]        latCnt;
    logic [31:0]       holdData;
    logic              errPending;
    logic [31:0]       mem [DEPTH];
    logic              accept;
    logic              inRange;
    logic [IDX_W-1:0]  wordIdx;

    assign accept  = iRAM_CE && oRAM_READY && (iRAM_RD || iRAM_WR);
    assign inRange = 32'(iRAM_ADDR) < DEPTH;
    assign wordIdx = IDX_W'(iRAM_ADDR);

    // Byte-enabled array write; the array has no reset so contents survive iRST_N
    always_ff @(posedge iCLK) begin
        if (accept && iRAM_WR && inRange)
            for (int b = 0; b < 4; b++)
                if (iRAM_BE[b]) mem[wordIdx][8*b +: 8] <= iRAM_DATA[8*b +: 8];
    end

    // Handshake, latency countdown and registered response strobes
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            latCnt     <= '0;
            holdData   <= '0;
            errPending <= 1'b0;
            oRAM_READY <= 1'b1;
            oRAM_VALID <= 1'b0;
            oRAM_DATA  <= '0;
            oRAM_ERR   <= 1'b0;
        end else begin
            oRAM_VALID <= 1'b0;
            oRAM_ERR   <= 1'b0;
            if (state == IDLE) begin
                if (accept && iRAM_RD) begin
                    state      <= WAIT;
                    oRAM_READY <= 1'b0;
                    latCnt     <= 4'(RD_LAT - 1);
                    holdData   <= inRange ? mem[wordIdx] : 32'h0;
                    errPending <= !inRange;
                end else if (accept) begin
                    oRAM_ERR <= !inRange;
                end
            end else if (latCnt == 4'd0) begin
                state      <= IDLE;
                oRAM_READY <= 1'b1;
                oRAM_VALID <= 1'b1;
                oRAM_ERR   <= errPending;
                oRAM_DATA  <= holdData;
            end else begin
                latCnt <= latCnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_rv32f_data_ram.sv
// tb_rv32f_data_ram: directed checks of writes, byte lanes, read latency, range errors and reset
module tb_rv32f_data_ram;
    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRAM_CE = 1'b0;
    logic        iRAM_RD = 1'b0;
    logic        iRAM_WR = 1'b0;
    logic [7:0]  iRAM_ADDR = '0;
    logic [3:0]  iRAM_BE = '0;
    logic [31:0] iRAM_DATA = '0;
    logic        oRAM_READY;
    logic        oRAM_VALID;
    logic [31:0] oRAM_DATA;
    logic        oRAM_ERR;
    int          tests = 0;
    int          fails = 0;

    rv32f_data_ram #(.DEPTH(128), .ADDR_W(8), .RD_LAT(2)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRAM_CE(iRAM_CE), .iRAM_RD(iRAM_RD),
        .iRAM_WR(iRAM_WR), .iRAM_ADDR(iRAM_ADDR), .iRAM_BE(iRAM_BE),
        .iRAM_DATA(iRAM_DATA), .oRAM_READY(oRAM_READY), .oRAM_VALID(oRAM_VALID),
        .oRAM_DATA(oRAM_DATA), .oRAM_ERR(oRAM_ERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
        iRAM_CE = rd | wr; iRAM_RD = rd; iRAM_WR = wr;
        iRAM_ADDR = addr; iRAM_BE = be; iRAM_DATA = data;
    endtask

    task automatic idle();
        setReq(1'b0, 1'b0, 8'h0, 4'h0, 32'h0);
    endtask

    task automatic doWrite(input logic [7:0] addr, input logic [3:0] be,
                           input logic [31:0] data, input logic expErr);
        setReq(1'b0, 1'b1, addr, be, data);
        @(negedge iCLK);
        chk("wr_ready", 32'(oRAM_READY), 32'd1);
        chk("wr_valid", 32'(oRAM_VALID), 32'd0);
        chk("wr_err", 32'(oRAM_ERR), 32'(expErr));
        idle();
    endtask

    task automatic doRead(input logic [7:0] addr, input logic wr, input logic [31:0] data,
                          input logic [31:0] expData, input logic expErr);
        setReq(1'b1, wr, addr, 4'hF, data);
        @(negedge iCLK);
        idle();
        chk("rd_ready_l1", 32'(oRAM_READY), 32'd0);
        chk("rd_valid_l1", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        chk("rd_ready_l2", 32'(oRAM_READY), 32'd0);
        chk("rd_valid_l2", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        chk("rd_valid", 32'(oRAM_VALID), 32'd1);
        chk("rd_data", oRAM_DATA, expData);
        chk("rd_err", 32'(oRAM_ERR), 32'(expErr));
        chk("rd_ready", 32'(oRAM_READY), 32'd1);
        @(negedge iCLK);
        chk("rd_valid_off", 32'(oRAM_VALID), 32'd0);
        chk("rd_data_hold", oRAM_DATA, expData);
    endtask

    initial begin
        @(negedge iCLK);
        chk("rst_ready", 32'(oRAM_READY), 32'd1);
        chk("rst_valid", 32'(oRAM_VALID), 32'd0);
        chk("rst_data", oRAM_DATA, 32'h0);
        chk("rst_err", 32'(oRAM_ERR), 32'd0);
        iRST_N = 1'b1;
        @(negedge iCLK);
        // basic write then read with 2-cycle latency
        doWrite(8'd5, 4'hF, 32'h3F800000, 1'b0);
        doRead(8'd5, 1'b0, 32'h0, 32'h3F800000, 1'b0);
        // back-to-back writes with partial byte enables
        doWrite(8'd9, 4'hF, 32'hFFFFFFFF, 1'b0);
        doWrite(8'd9, 4'b0101, 32'h12345678, 1'b0);
        doRead(8'd9, 1'b0, 32'h0, 32'hFF34FF78, 1'b0);
        // read+write returns old word, new word stored
        doWrite(8'd7, 4'hF, 32'h40000000, 1'b0);
        doRead(8'd7, 1'b1, 32'hC0000000, 32'h40000000, 1'b0);
        doRead(8'd7, 1'b0, 32'h0, 32'hC0000000, 1'b0);
        // request while busy is ignored until READY returns
        setReq(1'b1, 1'b0, 8'd5, 4'h0, 32'h0);
        @(negedge iCLK);
        setReq(1'b1, 1'b0, 8'd9, 4'h0, 32'h0);
        chk("busy_ready1", 32'(oRAM_READY), 32'd0);
        @(negedge iCLK);
        chk("busy_valid2", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        chk("busy_valid", 32'(oRAM_VALID), 32'd1);
        chk("busy_data", oRAM_DATA, 32'h3F800000);
        chk("busy_ready", 32'(oRAM_READY), 32'd1);
        @(negedge iCLK);
        idle();
        chk("held_accept", 32'(oRAM_READY), 32'd0);
        chk("held_valid_off", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        chk("held_valid_l2", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        chk("held_valid", 32'(oRAM_VALID), 32'd1);
        chk("held_data", oRAM_DATA, 32'hFF34FF78);
        @(negedge iCLK);
        // out-of-range accesses with DEPTH=128
        doWrite(8'd72, 4'hF, 32'h11111111, 1'b0);
        doWrite(8'd200, 4'hF, 32'hDEADBEEF, 1'b1);
        @(negedge iCLK);
        chk("oor_err_off", 32'(oRAM_ERR), 32'd0);
        doRead(8'd200, 1'b0, 32'h0, 32'h0, 1'b1);
        doRead(8'd72, 1'b0, 32'h0, 32'h11111111, 1'b0);
        // reset during WAIT discards the read, array retained
        doWrite(8'd3, 4'hF, 32'hA5A5A5A5, 1'b0);
        setReq(1'b1, 1'b0, 8'd3, 4'h0, 32'h0);
        @(negedge iCLK);
        idle();
        iRST_N = 1'b0;
        #1;
        chk("mid_rst_data", oRAM_DATA, 32'h0);
        chk("mid_rst_ready", 32'(oRAM_READY), 32'd1);
        @(negedge iCLK);
        chk("mid_rst_valid", 32'(oRAM_VALID), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        chk("post_rst_valid", 32'(oRAM_VALID), 32'd0);
        chk("post_rst_ready", 32'(oRAM_READY), 32'd1);
        chk("post_rst_data", oRAM_DATA, 32'h0);
        doRead(8'd3, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
